// File: rtl/clint_arb_pkg.sv
// Purpose : shared types and register offsets for the CLINT access arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package clint_arb_pkg;

  localparam int unsigned CLINT_ADDR_W = 16;
  localparam int unsigned CLINT_DATA_W = 64;
  localparam int unsigned CLINT_BE_W   = CLINT_DATA_W / 8;

  // Register offsets inside the timer/IPI block
  localparam logic [CLINT_ADDR_W-1:0] MSIP_BASE     = 16'h0000;
  localparam logic [CLINT_ADDR_W-1:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [CLINT_ADDR_W-1:0] MTIME_BASE    = 16'hBFF8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // One captured request; lock survives past ACCESS so RESP can decide the pointer update.
  typedef struct packed {
    logic                    we;
    logic                    lock;
    logic [CLINT_ADDR_W-1:0] addr;
    logic [CLINT_BE_W-1:0]   be;
    logic [CLINT_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/clint_rr_arbiter.sv
// Purpose : rotating-priority pick; first valid index at or after ptr, wrapping.
// Latency : combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports   : valid[N] in, ptr in (start index), grant[N] one-hot out, idx out, any out.
module clint_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos     = (32'(ptr) + k) % N;
      pos_idx = IDX_W'(pos);
      if (!any && valid[pos_idx]) begin
        any            = 1'b1;
        idx            = pos_idx;
        grant[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clint_access_arbiter.sv
// Purpose : round-robin share of one CLINT register port among NR_REQ requesters, one access in flight.
// Latency : accept T, reg_en_o T+1, rsp_valid_o T+2; at least 3 cycles per access.
// Backpressure: response held until rsp_ready_i of the granted port; no new accept meanwhile.
// Ports   : req_* (valid/ready/we/lock/addr/be/wdata per requester), rsp_* (valid/ready per requester,
//           shared rdata), reg_* (registered strobe/we/addr/be/wdata out, combinational rdata in).
// Option  : CLINT_ARB_LOCK_EN enables grant locking with an idle timeout of LOCK_TIMEOUT cycles.
module clint_access_arbiter
  import clint_arb_pkg::*;
#(
  parameter int unsigned NR_REQ       = 4,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NR_REQ-1:0]                   req_valid_i,
  output logic [NR_REQ-1:0]                   req_ready_o,
  input  logic [NR_REQ-1:0]                   req_we_i,
  input  logic [NR_REQ-1:0]                   req_lock_i,
  input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH/8-1:0] req_be_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NR_REQ-1:0]                   rsp_valid_o,
  input  logic [NR_REQ-1:0]                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic                                reg_en_o,
  output logic                                reg_we_o,
  output logic [ADDR_WIDTH-1:0]               reg_addr_o,
  output logic [DATA_WIDTH/8-1:0]             reg_be_o,
  output logic [DATA_WIDTH-1:0]               reg_wdata_o,
  input  logic [DATA_WIDTH-1:0]               reg_rdata_i
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, winner_q, next_ptr;
  arb_req_t          cap_q;
  logic              reg_en_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [NR_REQ-1:0] arb_valid, pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              hold_ptr;

  clint_rr_arbiter #(.N(NR_REQ), .IDX_W(IDX_W)) u_rr (
    .valid (arb_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef CLINT_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic             lock_vld_q;
  logic [IDX_W-1:0] lock_owner_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             lock_idle;

  // While locked only the owner may win, whatever the pointer says.
  assign arb_valid = lock_vld_q ? (req_valid_i & (NR_REQ'(1) << lock_owner_q)) : req_valid_i;
  // The owner finishing a lock=1 access keeps the lock, so the pointer stays put.
  assign hold_ptr  = cap_q.lock;
  assign lock_idle = (state_q == IDLE) && lock_vld_q && !req_valid_i[lock_owner_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      lock_cnt_q <= lock_idle ? lock_cnt_q + 1'b1 : '0;
      if ((state_q == IDLE) && pick_any && req_lock_i[pick_idx]) begin
        lock_vld_q   <= 1'b1;
        lock_owner_q <= pick_idx;
      end else if ((state_q == RESP) && rsp_ready_i[winner_q] && !cap_q.lock &&
                   lock_vld_q && (lock_owner_q == winner_q)) begin
        lock_vld_q <= 1'b0;
      end else if (lock_idle && (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1))) begin
        lock_vld_q <= 1'b0;
        lock_cnt_q <= '0;
      end
    end
  end
`else
  logic unused_lock;

  assign arb_valid   = req_valid_i;
  assign hold_ptr    = 1'b0;
  assign unused_lock = ^{req_lock_i, cap_q.lock};
`endif

  assign next_ptr = (winner_q == IDX_W'(NR_REQ - 1)) ? '0 : winner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready_o = pick_grant;
          state_d     = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rsp_valid_o[winner_q] = 1'b1;
        if (rsp_ready_i[winner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      cap_q    <= '0;
      reg_en_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            winner_q <= pick_idx;
            cap_q    <= '{we:    req_we_i[pick_idx],
                          lock:  req_lock_i[pick_idx],
                          addr:  CLINT_ADDR_W'(req_addr_i[pick_idx]),
                          be:    CLINT_BE_W'(req_be_i[pick_idx]),
                          wdata: CLINT_DATA_W'(req_wdata_i[pick_idx])};
            reg_en_q <= 1'b1;
          end
        end
        ACCESS: begin
          // Register port fields are cleared after the strobe cycle; lock is kept for RESP.
          reg_en_q    <= 1'b0;
          rdata_q     <= cap_q.we ? '0 : reg_rdata_i;
          cap_q.we    <= 1'b0;
          cap_q.addr  <= '0;
          cap_q.be    <= '0;
          cap_q.wdata <= '0;
        end
        RESP: begin
          if (rsp_ready_i[winner_q]) begin
            rdata_q <= '0;
            if (!hold_ptr) rr_ptr_q <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_en_o    = reg_en_q;
  assign reg_we_o    = cap_q.we;
  assign reg_addr_o  = ADDR_WIDTH'(cap_q.addr);
  assign reg_be_o    = (DATA_WIDTH/8)'(cap_q.be);
  assign reg_wdata_o = DATA_WIDTH'(cap_q.wdata);
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_clint_access_arbiter.sv
// Purpose : directed self-checking bench for clint_access_arbiter (default parameters).
// Latency : n/a.
// Backpressure: exercised through rsp_ready.
module tb_clint_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       req_valid, req_ready, req_we, req_lock, rsp_valid, rsp_ready;
  logic [3:0][15:0] req_addr;
  logic [3:0][7:0]  req_be;
  logic [3:0][63:0] req_wdata;
  logic [63:0]      rsp_rdata, reg_wdata, reg_rdata;
  logic             reg_en, reg_we;
  logic [15:0]      reg_addr;
  logic [7:0]       reg_be;

  int checks   = 0;
  int failures = 0;

  clint_access_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_lock_i  (req_lock),
    .req_addr_i  (req_addr),
    .req_be_i    (req_be),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .reg_en_o    (reg_en),
    .reg_we_o    (reg_we),
    .reg_addr_o  (reg_addr),
    .reg_be_o    (reg_be),
    .reg_wdata_o (reg_wdata),
    .reg_rdata_i (reg_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [3:0]  oh;
  int          exp_idx;

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 4'hF; reg_rdata = '0;
    tick(); tick(); rst = 1'b0; settle();

    // Reset state
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_reg_en", 64'(reg_en), 64'h0);
    chk("rst_rdata", rsp_rdata, 64'h0);
    chk("rst_reg_addr", 64'(reg_addr), 64'h0);
    chk("rst_reg_wdata", reg_wdata, 64'h0);

    // 1: single read of MTIME
    req_valid = 4'b0001; req_addr[0] = 16'hBFF8; settle();
    chk("t1_ready_T", 64'(req_ready), 64'h1);
    tick(); req_valid = '0; reg_rdata = 64'h1234; settle();
    chk("t1_en_T1", 64'(reg_en), 64'h1);
    chk("t1_addr_T1", 64'(reg_addr), 64'hBFF8);
    chk("t1_we_T1", 64'(reg_we), 64'h0);
    chk("t1_rsp_T1", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_T2", 64'(rsp_valid), 64'h1);
    chk("t1_rdata_T2", rsp_rdata, 64'h1234);
    chk("t1_en_off_T2", 64'(reg_en), 64'h0);
    chk("t1_addr_off_T2", 64'(reg_addr), 64'h0);
    tick(); reg_rdata = '0;
    chk("t1_rsp_done", 64'(rsp_valid), 64'h0);

    // 2: fairness from a fresh pointer; requester 1 writes
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) req_addr[i] = 16'(16'h0100 + 8 * i);
    req_we = 4'b0010; req_be[1] = 8'hFF; req_wdata[1] = 64'hDEAD_BEEF_0000_0001;
    req_valid = 4'hF; settle();
    for (int n = 0; n < 5; n++) begin
      exp_idx = n % 4;
      oh = 4'b0001 << exp_idx;
      chk("t2_ready", 64'(req_ready), 64'(oh));
      tick(); reg_rdata = 64'hA000 + 64'(exp_idx); settle();
      chk("t2_en", 64'(reg_en), 64'h1);
      chk("t2_addr", 64'(reg_addr), 64'h0100 + 64'(8 * exp_idx));
      chk("t2_no_accept_access", 64'(req_ready), 64'h0);
      if (exp_idx == 1) begin
        chk("t2_we", 64'(reg_we), 64'h1);
        chk("t2_be", 64'(reg_be), 64'hFF);
        chk("t2_wdata", reg_wdata, 64'hDEAD_BEEF_0000_0001);
      end
      tick();
      chk("t2_rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("t2_rdata", rsp_rdata, (exp_idx == 1) ? 64'h0 : 64'hA000 + 64'(exp_idx));
      tick();
    end

    // 3: backpressure on requester 1
    req_we = '0; rsp_ready = 4'b1101; settle();
    chk("t3_ready", 64'(req_ready), 64'h2);
    tick(); reg_rdata = 64'hCAFE_F00D;
    tick(); reg_rdata = 64'h5555;
    for (int c = 0; c < 10; c++) begin
      chk("t3_hold_valid", 64'(rsp_valid), 64'h2);
      chk("t3_hold_rdata", rsp_rdata, 64'hCAFE_F00D);
      chk("t3_no_accept", 64'(req_ready), 64'h0);
      tick();
    end
    rsp_ready = 4'hF; settle();
    tick();
    chk("t3_next_ready", 64'(req_ready), 64'h4);

    // 4: reset while in ACCESS
    tick();
    chk("t4_en_before", 64'(reg_en), 64'h1);
    chk("t4_addr_before", 64'(reg_addr), 64'h0110);
    req_valid = '0; rst = 1'b1; tick(); rst = 1'b0; settle();
    chk("t4_en_after", 64'(reg_en), 64'h0);
    chk("t4_rsp_after", 64'(rsp_valid), 64'h0);
    chk("t4_rdata_after", rsp_rdata, 64'h0);
    chk("t4_addr_after", 64'(reg_addr), 64'h0);
    tick();
    chk("t4_rsp_later", 64'(rsp_valid), 64'h0);
    chk("t4_en_later", 64'(reg_en), 64'h0);
    req_valid = 4'hF; settle();
    chk("t4_ptr_zero", 64'(req_ready), 64'h1);
    tick(); tick(); req_valid = '0; tick();

    // 5: locked lo/hi mtimecmp write pair from requester 2 while requester 0 waits
    req_valid = 4'b0101; req_we[2] = 1'b1; req_addr[2] = 16'h4000; req_be[2] = 8'h0F;
    req_lock[2] = 1'b1; req_wdata[2] = 64'h0000_0000_1111_2222; settle();
    chk("t5_first", 64'(req_ready), 64'h4);
    tick();
    chk("t5_lo_addr", 64'(reg_addr), 64'h4000);
    chk("t5_lo_be", 64'(reg_be), 64'h0F);
    chk("t5_lo_we", 64'(reg_we), 64'h1);
    chk("t5_lo_wdata", reg_wdata, 64'h0000_0000_1111_2222);
    req_addr[2] = 16'h4004; req_be[2] = 8'hF0; req_lock[2] = 1'b0;
    req_wdata[2] = 64'h3333_4444_0000_0000;
    tick(); tick();
`ifdef CLINT_ARB_LOCK_EN
    chk("t5_relock", 64'(req_ready), 64'h4);
    tick();
    chk("t5_hi_addr", 64'(reg_addr), 64'h4004);
    chk("t5_hi_be", 64'(reg_be), 64'hF0);
    tick(); tick(); req_valid[2] = 1'b0; settle();
    chk("t5_then_req0", 64'(req_ready), 64'h1);
`else
    chk("t5_rr_req0", 64'(req_ready), 64'h1);
    tick();
    chk("t5_req0_addr", 64'(reg_addr), 64'h0100);
    tick(); tick(); settle();
    chk("t5_then_req2", 64'(req_ready), 64'h4);
    tick();
    chk("t5_hi_addr", 64'(reg_addr), 64'h4004);
    chk("t5_hi_be", 64'(reg_be), 64'hF0);
    tick(); tick(); req_valid[2] = 1'b0; settle();
    chk("t5_last_req0", 64'(req_ready), 64'h1);
`endif
    tick(); tick(); req_valid = '0; tick();

    // 6: lock held by an idle requester 1 expires after the timeout
    req_valid = 4'b0010; req_lock[1] = 1'b1; req_we[1] = 1'b0; settle();
    chk("t6_ready1", 64'(req_ready), 64'h2);
    tick(); req_valid = '0; req_lock = '0;
    tick(); tick();
    req_valid = 4'b1000; settle();
`ifdef CLINT_ARB_LOCK_EN
    for (int c = 1; c <= 16; c++) begin
      chk("t6_locked_out", 64'(req_ready), 64'h0);
      tick();
    end
    chk("t6_timeout_grant", 64'(req_ready), 64'h8);
`else
    chk("t6_no_lock_grant", 64'(req_ready), 64'h8);
`endif
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
